// File: rtl/mem_responder.sv
// Backing-store responder for the CPU memory port: accepts one line request at a time,
// returns BEATS tagged read beats after LATENCY cycles, or absorbs BEATS masked write beats.
module mem_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int TAG_BITS   = 5,
  parameter int BEATS      = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [TAG_BITS-1:0]    mem_resp_tag,
  output logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int CNT_W  = BEAT_W + 1;
  localparam int LAT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BYTES  = DATA_BITS / 8;

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_BURST} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic                  req_ready_d, data_ready_d, resp_valid_d;
  logic [TAG_BITS-1:0]   resp_tag_d;
  logic                  rd_en, wr_en;
  logic [DEPTH_LOG2-1:0] idx;

  logic [DATA_BITS-1:0]  mem [DEPTH];

  // Only the in-storage line offset matters; higher bits alias and the beat offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[ADDR_BITS-1:DEPTH_LOG2], mem_req_addr[BEAT_W-1:0]};

  assign idx = base_q + DEPTH_LOG2'(beat_q);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    lat_d        = lat_q;
    base_d       = base_q;
    tag_d        = tag_q;
    req_ready_d  = mem_req_ready;
    data_ready_d = mem_req_data_ready;
    resp_valid_d = 1'b0;
    resp_tag_d   = mem_resp_tag;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_ready && mem_req_valid) begin
          req_ready_d = 1'b0;
          base_d      = {mem_req_addr[DEPTH_LOG2-1:BEAT_W], BEAT_W'(0)};
          tag_d       = mem_req_tag;
          beat_d      = '0;
          lat_d       = '0;
          if (mem_req_rw) begin
            state_d      = WR_DATA;
            data_ready_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WR_DATA: begin
        if (mem_req_data_valid && mem_req_data_ready) begin
          wr_en  = reset_n;
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == CNT_W'(BEATS - 1)) begin
            state_d      = IDLE;
            data_ready_d = 1'b0;
            req_ready_d  = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        // The storage read is registered, so the first beat is fetched one edge early.
        if (lat_q == LAT_W'(LATENCY - 2)) begin
          state_d      = RD_BURST;
          rd_en        = 1'b1;
          resp_valid_d = 1'b1;
          resp_tag_d   = tag_q;
          beat_d       = CNT_W'(1);
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RD_BURST: begin
        if (beat_q == CNT_W'(BEATS)) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          rd_en        = 1'b1;
          resp_valid_d = 1'b1;
          beat_d       = beat_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      beat_q             <= '0;
      lat_q              <= '0;
      mem_req_ready      <= 1'b0;
      mem_req_data_ready <= 1'b0;
      mem_resp_valid     <= 1'b0;
      mem_resp_tag       <= '0;
      mem_resp_data      <= '0;
    end else begin
      state_q            <= state_d;
      beat_q             <= beat_d;
      lat_q              <= lat_d;
      base_q             <= base_d;
      tag_q              <= tag_d;
      mem_req_ready      <= req_ready_d;
      mem_req_data_ready <= data_ready_d;
      mem_resp_valid     <= resp_valid_d;
      mem_resp_tag       <= resp_tag_d;
      if (rd_en) mem_resp_data <= mem[idx];
    end
  end

  // Storage has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_req_data_mask[b]) mem[idx][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table vectors, hand-written corner sequences and
// randomized traffic checked against a flat-array storage model.
module tb_mem_responder;

  localparam int AW = 28, DW = 128, TW = 5, BEATS = 4, DL = 12, LAT = 8;
  localparam int DEPTH = 1 << DL;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;
  logic mem_resp_valid;
  logic [TW-1:0] mem_resp_tag;
  logic [DW-1:0] mem_resp_data;

  mem_responder #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW),
    .BEATS(BEATS), .DEPTH_LOG2(DL), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef logic [BEATS-1:0][DW-1:0] line_t;
  typedef logic [BEATS-1:0][MW-1:0] lmask_t;

  typedef struct {
    logic [AW-1:0] wa;
    logic [TW-1:0] wt;
    line_t         wd;
    lmask_t        wm;
    logic [AW-1:0] ra;
    logic [TW-1:0] rt;
    line_t         exp;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] model [DEPTH];

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int beat_idx(input logic [AW-1:0] a, input int k);
    return (((int'(a) / BEATS) * BEATS) + k) % DEPTH;
  endfunction

  function automatic line_t model_line(input logic [AW-1:0] a);
    line_t r;
    for (int k = 0; k < BEATS; k++) r[k] = model[beat_idx(a, k)];
    return r;
  endfunction

  // Presents a request and returns once it has been accepted; 0 on timeout.
  task automatic accept_req(input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t, output bit ok);
    int waitc = 0;
    mem_req_rw = rw;
    mem_req_addr = a;
    mem_req_tag = t;
    mem_req_valid = 1'b1;
    while (!mem_req_ready && waitc < 200) begin
      tick();
      waitc++;
    end
    ok = mem_req_ready;
    if (!ok) checkOutput("req_accept_timeout", 0, 1);
    tick();
    mem_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [TW-1:0] t, input line_t d,
                          input lmask_t m, input int stall_after, input int stall_len);
    bit ok;
    int waitc;
    accept_req(1'b1, a, t, ok);
    if (!ok) return;
    checkOutput("wr_data_ready_after_accept", mem_req_data_ready, 1);
    for (int k = 0; k < BEATS; k++) begin
      mem_req_data_valid = 1'b1;
      mem_req_data_bits = d[k];
      mem_req_data_mask = m[k];
      waitc = 0;
      while (!mem_req_data_ready && waitc < 50) begin
        tick();
        waitc++;
      end
      if (!mem_req_data_ready) begin
        checkOutput("wr_data_timeout", 0, 1);
        mem_req_data_valid = 1'b0;
        return;
      end
      tick();
      for (int b = 0; b < MW; b++)
        if (m[k][b]) model[beat_idx(a, k)][b*8 +: 8] = d[k][b*8 +: 8];
      if (k == stall_after && k < BEATS - 1) begin
        mem_req_data_valid = 1'b0;
        repeat (stall_len) tick();
      end
    end
    mem_req_data_valid = 1'b0;
    checkOutput("wr_req_ready_after_last", mem_req_ready, 1);
    checkOutput("wr_data_ready_drop", mem_req_data_ready, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [TW-1:0] t, input line_t exp);
    bit ok;
    bit in_burst;
    accept_req(1'b0, a, t, ok);
    if (!ok) return;
    for (int c = 1; c <= LAT + BEATS; c++) begin
      in_burst = (c >= LAT) && (c < LAT + BEATS);
      checkOutput($sformatf("rd_valid_c%0d", c), mem_resp_valid, in_burst);
      if (in_burst) begin
        checkOutput($sformatf("rd_tag_c%0d", c), mem_resp_tag, t);
        checkOutput($sformatf("rd_data_beat%0d", c - LAT), mem_resp_data, exp[c - LAT]);
      end
      checkOutput($sformatf("rd_req_ready_c%0d", c), mem_req_ready, c == LAT + BEATS);
      if (c < LAT + BEATS) tick();
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    do_write(v.wa, v.wt, v.wd, v.wm, -1, 0);
    do_read(v.ra, v.rt, v.exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    line_t stall_line, junk_dummy;
    lmask_t full_m;
    int pool[$];
    bit ok;
    logic [AW-1:0] a;
    line_t rd;
    lmask_t rm;

    reset_n = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_rw = 1'b0;
    mem_req_addr = '0;
    mem_req_tag = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits = '0;
    mem_req_data_mask = '0;
    for (int k = 0; k < BEATS; k++) full_m[k] = '1;

    // Reset held with a request pending: everything stays quiet.
    repeat (3) begin
      tick();
      checkOutput("reset_ctrl", {mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_tag}, 0);
      checkOutput("reset_data", mem_resp_data, 0);
    end
    mem_req_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    checkOutput("ready_after_release", mem_req_ready, 1);
    repeat (LAT + BEATS) begin
      tick();
      checkOutput("no_resp_after_reset", mem_resp_valid, 0);
    end

    // Vector table: write a line then read it back through a possibly different alias.
    vecs[0].wa = 28'h10; vecs[0].wt = 5'd3; vecs[0].ra = 28'h12; vecs[0].rt = 5'd7;
    vecs[1].wa = 28'h20; vecs[1].wt = 5'd1; vecs[1].ra = 28'h20; vecs[1].rt = 5'd2;
    vecs[2].wa = 28'h20; vecs[2].wt = 5'd4; vecs[2].ra = 28'h23; vecs[2].rt = 5'd5;
    vecs[3].wa = 28'hFFC; vecs[3].wt = 5'd6; vecs[3].ra = 28'h1FFC; vecs[3].rt = 5'h1F;
    for (int k = 0; k < BEATS; k++) begin
      vecs[0].wd[k] = {120'h112233445566778899AABBCCDDEEFF, 8'hA0 + 8'(k)};
      vecs[0].exp[k] = {120'h112233445566778899AABBCCDDEEFF, 8'hA0 + 8'(k)};
      vecs[0].wm[k] = 16'hFFFF;
      vecs[1].wd[k] = '1;
      vecs[1].exp[k] = '1;
      vecs[1].wm[k] = 16'hFFFF;
      vecs[2].wd[k] = '0;
      vecs[2].exp[k] = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0};
      vecs[2].wm[k] = 16'h000F;
      vecs[3].wd[k] = {4{32'hCAFE0000 | 32'(k)}};
      vecs[3].exp[k] = {4{32'hCAFE0000 | 32'(k)}};
      vecs[3].wm[k] = 16'hFFFF;
    end
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Stray write data before the request is accepted must not be consumed; then a stalled write.
    mem_req_data_valid = 1'b1;
    mem_req_data_bits = {16{8'h5A}};
    mem_req_data_mask = '1;
    repeat (2) begin
      tick();
      checkOutput("idle_data_ready_low", mem_req_data_ready, 0);
    end
    for (int k = 0; k < BEATS; k++) stall_line[k] = {4{32'h0B0B0000 + 32'(k)}};
    do_write(28'h40, 5'd8, stall_line, full_m, 1, 2);
    do_read(28'h41, 5'd9, stall_line);

    // Reset during beat 1 of a burst, then a clean re-read of the same line.
    accept_req(1'b0, 28'h10, 5'd10, ok);
    if (ok) begin
      repeat (LAT) tick();
      checkOutput("mid_beat1_valid", mem_resp_valid, 1);
      checkOutput("mid_beat1_data", mem_resp_data, vecs[0].exp[1]);
      reset_n = 1'b0;
      tick();
      checkOutput("abort_resp_valid", mem_resp_valid, 0);
      checkOutput("abort_req_ready", mem_req_ready, 0);
      tick();
      reset_n = 1'b1;
      tick();
      checkOutput("ready_after_abort", mem_req_ready, 1);
      do_read(28'h10, 5'd11, vecs[0].exp);
    end

    // Randomized traffic over a small pool of fully-initialized lines, reached via aliases.
    junk_dummy = '0;
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1)) & ~AW'(BEATS - 1);
      for (int k = 0; k < BEATS; k++) rd[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_write(a, TW'($urandom), rd, full_m, -1, 0);
      pool.push_back(int'(a));
    end
    for (int i = 0; i < 16; i++) begin
      a = AW'(pool[$urandom_range(0, pool.size() - 1)] + DEPTH * $urandom_range(0, 255)
              + $urandom_range(0, BEATS - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BEATS; k++) begin
          rd[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
          rm[k] = MW'($urandom);
        end
        do_write(a, TW'($urandom), rd, rm, $urandom_range(0, BEATS - 2), $urandom_range(0, 3));
      end else begin
        do_read(a, TW'($urandom), model_line(a));
      end
    end
    for (int i = 0; i < 6; i++) do_read(AW'(pool[i]), TW'(i), model_line(AW'(pool[i])));

    if (junk_dummy != '0) $display("[TB] note: unexpected scratch value");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable backing-store responder for the CPU memory port: it is the far end of the mem_req / mem_req_data / mem_resp interface that the core-plus-cache subsystem drives as initiator.
- Accepts one line-sized request at a time. Reads return BEATS data beats carrying the request tag; writes absorb BEATS masked data beats.
- Used as the main-memory model in full-chip simulation and as the on-chip scratch backing store.

Parameters:
- ADDR_BITS, 28, width of mem_req_addr; the address is in units of one DATA_BITS-wide beat.
- DATA_BITS, 128, width of one data beat.
- TAG_BITS, 5, request/response tag width.
- BEATS, 4, beats per line; must be a power of two, at least 2.
- DEPTH_LOG2, 12, log2 of storage depth in beats.
- LATENCY, 8, cycles from read accept to first response beat; must be at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- mem_req_valid  in  1  request valid.
- mem_req_ready  out  1  responder can accept a request.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_addr  in  ADDR_BITS  line address (beat units; low log2(BEATS) bits ignored).
- mem_req_tag  in  TAG_BITS  request tag.
- mem_req_data_valid  in  1  write data beat valid.
- mem_req_data_ready  out  1  responder accepts a write data beat.
- mem_req_data_bits  in  DATA_BITS  write data beat.
- mem_req_data_mask  in  DATA_BITS/8  per-byte write enable; bit i covers byte i.
- mem_resp_valid  out  1  read beat valid; there is no back-pressure.
- mem_resp_tag  out  TAG_BITS  tag of the read being returned.
- mem_resp_data  out  DATA_BITS  read beat data.

Behaviour:
- States: IDLE, WR_DATA, RD_WAIT, RD_BURST.
- Reset (reset_n low at a clock edge):
  - state goes to IDLE; beat and latency counters clear.
  - mem_req_ready=0, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0.
  - Storage contents are NOT cleared.
  - Reset mid-burst aborts the operation. No further beats are emitted or written, and beats already written remain in storage.
- All outputs are registered.
- mem_req_ready is 1 only in IDLE and not in reset.
- mem_req_data_ready is 1 only in WR_DATA.
- Request accept happens when mem_req_valid && mem_req_ready at edge T. At accept, the responder latches rw, tag and the line base = addr with its low log2(BEATS) bits zeroed.
- Storage index for beat k = (base + k) modulo 2^DEPTH_LOG2. Address bits above that width are ignored, so addresses alias and wrap.
- Write path:
  - IDLE goes to WR_DATA at T.
  - mem_req_data_ready is 1 from T+1.
  - Each edge with data_valid && data_ready writes beat k (k = 0, 1, ... in order). Bytes with mask bit 0 are left unchanged.
  - Cycles where mem_req_data_valid is low stall without penalty.
  - After beat BEATS-1 is accepted, go to IDLE; data_ready drops and req_ready rises on the next cycle.
  - Data beats presented before the request is accepted are ignored (data_ready=0). Write data is never accepted while in IDLE.
  - No write response is generated.
- Read path:
  - IDLE goes to RD_WAIT at T.
  - mem_resp_valid=1 for exactly BEATS consecutive cycles, T+LATENCY through T+LATENCY+BEATS-1. Beat k carries storage[base+k] and the latched tag.
  - mem_req_ready returns to 1 at T+LATENCY+BEATS.
- Read-after-write to the same line returns the newly written data, because the write completes before the read can be accepted.
- Only one request is outstanding at a time, so request accept and data/response activity never overlap.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with mem_req_valid=1 -> all outputs 0 throughout and nothing accepted. Release reset -> mem_req_ready=1 on the next cycle.
- Write then read, full mask:
  - Write addr=0x10, tag=3, beats 0x...A0 to 0x...A3, mask all ones.
  - Then read addr=0x12, tag=7.
  - Required: 4 resp beats 0x...A0 to 0x...A3 with tag 7. Beat 0 at exactly accept+8. No request accepted during the burst.
- Partial mask:
  - Write line 0x20 with all 0xFF bytes, then rewrite it with data 0 and mask 0x000F.
  - Read line 0x20 -> each beat = 0xFFFF...FFFF_0000_0000 (low 4 bytes cleared).
- Write data stall:
  - Insert 2 idle data_valid cycles between beats 1 and 2 -> all 4 beats stored correctly.
  - mem_req_ready rises the cycle after the 4th data handshake.
  - A data beat driven with valid before the request accept is not consumed.
- Wrap and alias: write line (2^DEPTH_LOG2 - 4), then read addr + 2^DEPTH_LOG2 -> identical data returned.
- Reset mid-read: assert reset_n=0 during beat 1 of a burst -> mem_resp_valid=0 the next cycle. After release, a new read of the same line returns the full correct line.
